// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer between the APB TX-data register and UART_TX.
// Bytes are queued in a circular buffer and launched one at a time using
// the tx_en / tx_busy / tx_done handshake, so back-to-back writes survive
// a slow serial frame.
module uart_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              push;
  logic              pop;

  // full/empty come from the registered count, so a push in the same cycle
  // as a pop at full is still refused.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A flush wins over any push or launch in the same cycle.
  assign push = wr_en && !full && !clear;
  assign pop  = (state == IDLE) && !empty && !tx_busy && !clear;

  // Byte storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Launch outputs: one-cycle start pulse and the byte held until next launch.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= pop;
      if (pop) begin
        tx_data <= mem[rptr];
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic following the UART through start, busy and done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tx_done) begin
          state_next = IDLE;
        end else if (tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_done) begin
          state_next = IDLE;
        end else if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference model,
// a small UART stub, a per-cycle compare and directed scenarios.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int FRAME_LEN = 5;

  logic             clk       = 1'b0;
  logic             arst_n    = 1'b0;
  logic             wr_en     = 1'b0;
  logic [7:0]       wr_data   = 8'h00;
  logic             clear     = 1'b0;
  logic             tx_busy   = 1'b0;
  logic             tx_done   = 1'b0;
  logic             full;
  logic             empty;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic             tx_en;
  logic [7:0]       tx_data;

  logic             stub_hold = 1'b0;
  int               stub_cnt  = 0;
  int               checks    = 0;
  int               errors    = 0;

  logic [7:0]       mq[$];
  logic             m_ovf    = 1'b0;
  logic             m_en     = 1'b0;
  logic [7:0]       m_data   = 8'h00;
  logic             m_wait   = 1'b0;
  logic             m_launch = 1'b0;
  int               m_size   = 0;

  logic [7:0]       sent[$];
  logic [7:0]       exp_bytes[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clear    (clear),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Reference model: a byte queue plus a single "frame outstanding" flag.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_en   = 1'b0;
      m_data = 8'h00;
      m_wait = 1'b0;
    end else begin
      m_size   = mq.size();
      m_launch = !m_wait && (m_size > 0) && !tx_busy && !clear;
      if (m_wait && tx_done) m_wait = 1'b0;
      if (clear) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (m_launch) m_data = mq.pop_front();
        if (wr_en) begin
          if (m_size == DEPTH) m_ovf = 1'b1;
          else mq.push_back(wr_data);
        end
      end
      if (m_launch) m_wait = 1'b1;
      m_en = m_launch;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic c);
    wr_en   = w;
    wr_data = d;
    clear   = c;
    step();
    wr_en   = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic checkSent(input string name);
    checkOutput($sformatf("%s_len", name), 32'(sent.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < sent.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", name, i), 32'(sent[i]), 32'(exp_bytes[i]));
    end
  endtask

  // Stimulus, UART stub and per-cycle compare all live in this one process tree.
  initial begin
    fork
      forever begin
        @(negedge clk);
        tx_done = 1'b0;
        if (!arst_n) begin
          stub_cnt = 0;
          tx_busy  = 1'b0;
        end else if (stub_hold) begin
          tx_busy = 1'b1;
        end else if (stub_cnt > 0) begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            tx_busy = 1'b0;
            tx_done = 1'b1;
          end
        end else if (tx_en) begin
          tx_busy  = 1'b1;
          stub_cnt = FRAME_LEN;
        end else begin
          tx_busy = 1'b0;
        end
      end
      forever begin
        @(negedge clk);
        if (tx_en === 1'b1) sent.push_back(tx_data);
        checkOutput("cyc_count", 32'(count), 32'(mq.size()));
        checkOutput("cyc_empty", 32'(empty), 32'(mq.size() == 0));
        checkOutput("cyc_full", 32'(full), 32'(mq.size() == DEPTH));
        checkOutput("cyc_overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("cyc_tx_en", 32'(tx_en), 32'(m_en));
        checkOutput("cyc_tx_data", 32'(tx_data), 32'(m_data));
      end
    join_none

    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    arst_n = 1'b1;
    step();
    step();

    $display("[TB] single byte");
    sent.delete();
    applyStimulus(1'b1, 8'h51, 1'b0);
    checkOutput("t1_count_after_push", 32'(count), 32'd1);
    checkOutput("t1_empty_after_push", 32'(empty), 32'd0);
    checkOutput("t1_tx_en_early", 32'(tx_en), 32'd0);
    step();
    checkOutput("t1_tx_en", 32'(tx_en), 32'd1);
    checkOutput("t1_tx_data", 32'(tx_data), 32'h51);
    checkOutput("t1_count_after_pop", 32'(count), 32'd0);
    checkOutput("t1_empty_after_pop", 32'(empty), 32'd1);
    step();
    checkOutput("t1_tx_en_one_cycle", 32'(tx_en), 32'd0);
    repeat (15) step();
    exp_bytes = '{8'h51};
    checkSent("t1_sent");

    $display("[TB] burst");
    sent.delete();
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("t2_count_mid", 32'(count), 32'd1);
    checkOutput("t2_first_launch", 32'(tx_data), 32'h11);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("t2_count_peak", 32'(count), 32'd2);
    repeat (40) step();
    exp_bytes = '{8'h11, 8'h22, 8'h33};
    checkSent("t2_sent");

    $display("[TB] full and overflow");
    sent.delete();
    stub_hold = 1'b1;
    step();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == 8) begin
        checkOutput("t3_full_at8", 32'(full), 32'd1);
        checkOutput("t3_count_at8", 32'(count), 32'd8);
        checkOutput("t3_ovf_at8", 32'(overflow), 32'd0);
      end
    end
    checkOutput("t3_count_at9", 32'(count), 32'd8);
    checkOutput("t3_ovf_at9", 32'(overflow), 32'd1);
    stub_hold = 1'b0;
    repeat (100) step();
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    checkSent("t3_sent");
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] push and pop at full");
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t4_clear_count", 32'(count), 32'd0);
    checkOutput("t4_clear_ovf", 32'(overflow), 32'd0);
    stub_hold = 1'b1;
    step();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
    checkOutput("t4_count_full", 32'(count), 32'd8);
    sent.delete();
    stub_hold = 1'b0;
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("t4_count", 32'(count), 32'd7);
    checkOutput("t4_ovf", 32'(overflow), 32'd1);
    checkOutput("t4_full", 32'(full), 32'd0);
    checkOutput("t4_tx_en", 32'(tx_en), 32'd1);
    checkOutput("t4_tx_data", 32'(tx_data), 32'hA0);
    repeat (100) step();
    exp_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    checkSent("t4_sent");

    $display("[TB] clear during frame");
    sent.delete();
    applyStimulus(1'b1, 8'hB1, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0);
    applyStimulus(1'b1, 8'hB3, 1'b0);
    applyStimulus(1'b1, 8'hB4, 1'b0);
    checkOutput("t5_count_before", 32'(count), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5_count", 32'(count), 32'd0);
    checkOutput("t5_empty", 32'(empty), 32'd1);
    checkOutput("t5_ovf", 32'(overflow), 32'd0);
    repeat (30) step();
    exp_bytes = '{8'hB1};
    checkSent("t5_sent");

    $display("[TB] async reset mid-frame");
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
    checkOutput("t6_count_before", 32'(count), 32'd4);
    checkOutput("t6_tx_data_before", 32'(tx_data), 32'hC1);
    arst_n = 1'b0;
    #1;
    checkOutput("t6_tx_data", 32'(tx_data), 32'h00);
    checkOutput("t6_tx_en", 32'(tx_en), 32'd0);
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_empty", 32'(empty), 32'd1);
    step();
    arst_n = 1'b1;
    step();
    sent.delete();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (20) step();
    exp_bytes = '{8'hA5};
    checkSent("t6_sent");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer between the APB register block and UART_TX. It accepts bytes from the APB TX-data register write strobe, stores up to DEPTH of them, and feeds UART_TX one byte at a time using its tx_en/tx_data/tx_busy/tx_done handshake. Back-to-back APB writes are therefore never lost while a 9600-baud frame is in flight.

Parameters:
DEPTH, 8, number of byte entries; must be a power of two, 2..256
ADDR_W, 3, log2(DEPTH); pointer width
DATA_W, 8, byte width; fixed at 8 to match UART_TX

Ports:
clk  in  1  system clock, same clock as APB and UART_TX
arst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  single-cycle push strobe from the APB block's TX-data register write
wr_data  in  8  byte to push
clear  in  1  synchronous flush of stored bytes
full  out  1  FIFO holds DEPTH bytes
empty  out  1  FIFO holds 0 bytes
count  out  ADDR_W+1  number of stored bytes, 0..DEPTH
overflow  out  1  sticky flag: a push was dropped
tx_en  out  1  one-cycle start pulse to UART_TX
tx_data  out  8  byte presented to UART_TX; held stable until the next launch
tx_busy  in  1  from UART_TX: frame in progress
tx_done  in  1  from UART_TX: one-cycle end-of-frame pulse

Behaviour:
- Reset (arst_n low, asynchronous): pointers 0, count 0, empty 1, full 0, overflow 0, tx_en 0, tx_data 8'h00, FSM state IDLE. Storage contents are don't-care.
- Storage: circular buffer. Read and write pointers are ADDR_W bits and wrap DEPTH-1 -> 0. count is tracked explicitly. full = (count==DEPTH). empty = (count==0).
- Push: accepted when wr_en=1 and full=0. On acceptance, mem[wptr] <= wr_data, wptr++, count++.
- Push while full: wr_en=1 with full=1 drops the byte. No pointer or count change. overflow <= 1 and stays set until clear or reset.
- Pop: happens only in the FSM IDLE->LAUNCH transition. tx_data <= mem[rptr], rptr++, count--.
- Push and pop in the same cycle:
  - count is unchanged.
  - With full=1, the push is still rejected, because full is evaluated from the registered count.
  - With empty=1, no pop occurs; the pushed byte becomes eligible on the next cycle.
- FSM, all registered outputs:
  - IDLE: if empty=0 and tx_busy=0 -> pop, tx_en <= 1, go to LAUNCH.
  - LAUNCH: tx_en <= 0. If tx_done=1 -> IDLE. Else if tx_busy=1 -> WAIT_DONE. Else -> WAIT_BUSY.
  - WAIT_BUSY: if tx_done=1 -> IDLE. Else if tx_busy=1 -> WAIT_DONE. This covers a UART that asserts busy late.
  - WAIT_DONE: if tx_done=1 -> IDLE.
- tx_en is high for exactly one cycle per popped byte, and only in the cycle after the pop decision. It is never asserted while tx_busy=1 was sampled in IDLE.
- Latency: a push at edge N into an empty FIFO with UART idle -> empty=0 after N. Pop decision at edge N+1 -> tx_en=1 and tx_data valid during cycle N+1..N+2.
- Minimum inter-byte gap: tx_done in cycle M -> IDLE at edge M. Next tx_en rises at edge M+1 if data is pending.
- clear=1:
  - Sets pointers to 0, count to 0, overflow to 0.
  - A push in the same cycle is discarded; clear has priority and does not set overflow.
  - Does not touch FSM state or tx_data: an in-flight frame completes and the FSM returns to IDLE normally.
- Reset mid-frame: everything returns to reset values immediately. The UART shares arst_n, so no orphan handshake remains.
- The FSM never enters an undefined state. Unused encodings go to IDLE.

Test Plan:
1. Single byte: after reset, push 8'h51 with UART idle -> tx_en pulses for 1 cycle, 1 clk after the push edge, with tx_data=8'h51. count goes 0 -> 1 -> 0. empty returns to 1. Loopback UART_RX reports rx_data=8'h51 after about 1.04 ms at 100 MHz / 9600 baud.
2. Burst: push 8'h11, 8'h22, 8'h33 on consecutive cycles -> count peaks at 2 (one byte already popped). tx_en fires three times in order 11, 22, 33. Each subsequent tx_en comes exactly 1 clk after the previous tx_done.
3. Full/overflow: hold tx_busy=1 (UART stubbed), push 9 bytes 8'h01..8'h09 -> after the 8th push full=1 and count=8. The 9th push is dropped and overflow=1. Release busy, pulse tx_done as each frame ends -> bytes 01..08 are emitted and 09 is never emitted.
4. Simultaneous push/pop at full: count=8, and in the same cycle a pop occurs and wr_en=1 -> the push is rejected, overflow=1, count=7.
5. Clear during a frame: 3 bytes queued and one frame in WAIT_DONE, pulse clear -> count=0, empty=1, overflow=0. The current frame still ends with tx_done, and no further tx_en occurs.
6. Async reset mid-frame: drop arst_n between clock edges while in WAIT_DONE with count=4 -> all outputs immediately reach reset values (tx_data=8'h00, tx_en=0, count=0). After release, a push of 8'hA5 is transmitted normally.
